alu_issue: RTL and testbench

Execute-issue stage directly upstream of the ALU: accepts decoded instructions over a valid/ready handshake, resolves operands with EX/MEM forwarding and immediate selection, and holds them in the ID/EX pipeline register that drives the ALU `op`/`A`/`B` inputs. It also detects load-use hazards and inserts bubbles, supports flush, and keeps the ALU inputs stable while downstream back-pressures.

---
 rtl/alu_issue.sv | 178 +++++++++++++++++
 tb/tb_alu_issue.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue
//
// Execute-issue stage that sits directly in front of the ALU.
// - Accepts decoded instructions over a valid/ready handshake.
// - Resolves both source operands with EX/MEM forwarding, and selects the
//   immediate for B when asked.
// - Holds the result in the ID/EX register, which drives the ALU op/A/B
//   inputs.
// - Inserts a single bubble on a load-use dependency.
// - Supports flush.
// - Freezes the ALU inputs while downstream back-pressures.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : decoded-instruction handshake
//   in_op             : ALU opcode, passed through unchanged
//   in_rs/in_rt       : source register indices
//   in_rs_val/in_rt_val : register-file read data
//   in_imm/in_use_imm : extended immediate, and select for the B operand
//   in_rd/in_wen/in_load : destination index, write enable, load flag
//   flush             : kill the EX slot and any same-cycle transfer
//   alu_out           : ALU result of the instruction in EX (forwarding source)
//   mem_valid/mem_wen/mem_rd/mem_data : MEM-stage writeback (forwarding source)
//   ex_ready          : downstream accepts the EX slot
//   ex_valid, alu_op, alu_a, alu_b, ex_rt_val, ex_rd, ex_wen, ex_load :
//                       EX slot contents
//
// Optional build macro
//   ALU_ISSUE_PERF_EN : adds the perf_issued and perf_hz_stalls counters.
//                       Both are 32 bits and wrap.

module alu_issue (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   input  logic [31:0] in_imm,
   input  logic        in_use_imm,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   input  logic        in_load,

   input  logic        flush,

   input  logic [31:0] alu_out,
   input  logic        mem_valid,
   input  logic        mem_wen,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,

   input  logic        ex_ready,
   output logic        ex_valid,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [31:0] ex_rt_val,
   output logic [4:0]  ex_rd,
   output logic        ex_wen,
   output logic        ex_load
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_hz_stalls
`endif
);

   logic        adv;
   logic        rt_used;
   logic        hz;
   logic        xfer;
   logic        ex_fwd_ok;
   logic        mem_fwd_ok;
   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic [31:0] opnd_b;

   assign adv = !ex_valid | ex_ready;

   // Stores (no writeback) read rt as store data even when B is the
   // immediate, so their rt must count for the load-use check.
   assign rt_used = !in_use_imm | !in_wen;

   assign hz = in_valid & ex_valid & ex_load & (ex_rd != 5'd0) &
               ((ex_rd == in_rs) | ((ex_rd == in_rt) & rt_used));

   // Gating with rst_n keeps the handshake closed while reset is held.
   assign in_ready = rst_n & adv & !hz & !flush;
   assign xfer     = in_valid & in_ready;

   // A load in EX has no data yet, so it is never an EX forwarding source.
   // The hazard logic covers that case instead.
   assign ex_fwd_ok  = ex_valid & ex_wen & !ex_load & (ex_rd != 5'd0);
   assign mem_fwd_ok = mem_valid & mem_wen & (mem_rd != 5'd0);

   // Both sources must be non-zero for a match, so r0 always reads the
   // register file.
   always_comb begin
      fwd_rs = in_rs_val;
      if (ex_fwd_ok && (ex_rd == in_rs)) begin
         fwd_rs = alu_out;
      end else if (mem_fwd_ok && (mem_rd == in_rs)) begin
         fwd_rs = mem_data;
      end
   end

   always_comb begin
      fwd_rt = in_rt_val;
      if (ex_fwd_ok && (ex_rd == in_rt)) begin
         fwd_rt = alu_out;
      end else if (mem_fwd_ok && (mem_rd == in_rt)) begin
         fwd_rt = mem_data;
      end
   end

   assign opnd_b = in_use_imm ? in_imm : fwd_rt;

   // Valid bit.
   // - Flush wins over everything.
   // - When the slot advances without a transfer, a bubble is left behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (adv) begin
         ex_valid <= xfer;
      end
   end

   // Payload only changes on a real transfer. This keeps the ALU inputs
   // bit-stable through stalls, bubbles and flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op    <= 5'd0;
         alu_a     <= 32'd0;
         alu_b     <= 32'd0;
         ex_rt_val <= 32'd0;
         ex_rd     <= 5'd0;
         ex_wen    <= 1'b0;
         ex_load   <= 1'b0;
      end else if (xfer) begin
         alu_op    <= in_op;
         alu_a     <= fwd_rs;
         alu_b     <= opnd_b;
         ex_rt_val <= fwd_rt;
         ex_rd     <= in_rd;
         ex_wen    <= in_wen;
         ex_load   <= in_load;
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   logic hz_stall;

   assign hz_stall = in_valid & hz & adv & !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued    <= 32'd0;
         perf_hz_stalls <= 32'd0;
      end else begin
         if (xfer) begin
            perf_issued <= perf_issued + 32'd1;
         end
         if (hz_stall) begin
            perf_hz_stalls <= perf_hz_stalls + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue.
// - First runs directed steps for the listed scenarios.
// - Then runs a randomized program.
// - The random program is checked against in-order reference semantics: the
//   bench acts as the ALU and the MEM stage, and keeps a committed register
//   file plus a program-order register file. Each issued instruction must see
//   exactly the program-order values of its sources.
module tb_alu_issue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic [31:0] in_imm;
   logic        in_use_imm;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        in_load;
   logic        flush;
   logic [31:0] alu_out;
   logic        mem_valid;
   logic        mem_wen;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        ex_ready;
   logic        ex_valid;
   logic [4:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] ex_rt_val;
   logic [4:0]  ex_rd;
   logic        ex_wen;
   logic        ex_load;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_hz_stalls;
`endif

   alu_issue dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rs_val  (in_rs_val),
      .in_rt_val  (in_rt_val),
      .in_imm     (in_imm),
      .in_use_imm (in_use_imm),
      .in_rd      (in_rd),
      .in_wen     (in_wen),
      .in_load    (in_load),
      .flush      (flush),
      .alu_out    (alu_out),
      .mem_valid  (mem_valid),
      .mem_wen    (mem_wen),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .ex_ready   (ex_ready),
      .ex_valid   (ex_valid),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .ex_rt_val  (ex_rt_val),
      .ex_rd      (ex_rd),
      .ex_wen     (ex_wen),
      .ex_load    (ex_load)
`ifdef ALU_ISSUE_PERF_EN
      ,
      .perf_issued    (perf_issued),
      .perf_hz_stalls (perf_hz_stalls)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                        input logic ui, input logic [4:0] rd, input logic wen, input logic ld);
      in_valid   = 1'b1;
      in_op      = op;
      in_rs      = rs;
      in_rt      = rt;
      in_rs_val  = rsv;
      in_rt_val  = rtv;
      in_imm     = imm;
      in_use_imm = ui;
      in_rd      = rd;
      in_wen     = wen;
      in_load    = ld;
   endtask

   // Stand-ins for the ALU and data memory used by the random program.
   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      return a + b + {27'd0, op};
   endfunction

   function automatic logic [31:0] memval(input logic [31:0] addr);
      return addr ^ 32'hC3A5_5A3C;
   endfunction

   // Reference state for the random phase.
   logic [31:0] rf     [32];
   logic [31:0] golden [32];
   logic        s_v, s_wen, s_ld, s_rtu;
   logic [4:0]  s_op, s_rd;
   logic [31:0] s_a, s_b, s_rtv, s_res;
   logic        m_v, m_wen;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        p_v, p_ui, p_wen, p_ld;
   logic [4:0]  p_op, p_rs, p_rt, p_rd;
   logic [31:0] p_imm;
   logic        hz_m, adv_m, rdy_m, acc_m, fire_m;
   logic [31:0] ga, grtv, gb;
   int          n_issue_m;
   int          n_hz_m;
   int          kind;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b1; in_op = 5'd0; in_rs = 5'd0; in_rt = 5'd0;
      in_rs_val = 32'd0; in_rt_val = 32'd0; in_imm = 32'd0; in_use_imm = 1'b0;
      in_rd = 5'd0; in_wen = 1'b0; in_load = 1'b0; flush = 1'b0;
      alu_out = 32'hDEAD_BEEF; mem_valid = 1'b0; mem_wen = 1'b0; mem_rd = 5'd0;
      mem_data = 32'h0BAD_F00D; ex_ready = 1'b1;

      // Reset state
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_ex_rt_val", ex_rt_val, 32'd0);
      chk("rst_ex_rd", 32'(ex_rd), 32'd0);
      chk("rst_ex_wen_load", {30'd0, ex_wen, ex_load}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
      chk("rst_perf_issued", perf_issued, 32'd0);
      chk("rst_perf_hz", perf_hz_stalls, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back independent
      drive(5'd0, 5'd1, 5'd2, 32'd108, 32'd62, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      #1 chk("b2b_ready", 32'(in_ready), 32'd1);
      tick();
      chk("b2b1_valid", 32'(ex_valid), 32'd1);
      chk("b2b1_a", alu_a, 32'd108);
      chk("b2b1_b", alu_b, 32'd62);
      chk("b2b1_op", 32'(alu_op), 32'd0);
      drive(5'd4, 5'd7, 5'd8, 32'hA000_0000, 32'd9, 32'h5000_0000, 1'b1, 5'd0, 1'b1, 1'b0);
      tick();
      chk("b2b2_valid", 32'(ex_valid), 32'd1);
      chk("b2b2_a", alu_a, 32'hA000_0000);
      chk("b2b2_b", alu_b, 32'h5000_0000);
      chk("b2b2_op", 32'(alu_op), 32'd4);

      // EX forwarding, then the r0 case
      drive(5'd0, 5'd1, 5'd2, 32'd1, 32'd1, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      tick();
      drive(5'd1, 5'd3, 5'd2, 32'd0, 32'd5, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      alu_out = 32'h7FFF_FFFF;
      tick();
      chk("exfwd_a", alu_a, 32'h7FFF_FFFF);
      chk("exfwd_b", alu_b, 32'd5);
      chk("exfwd_op", 32'(alu_op), 32'd1);
      drive(5'd0, 5'd1, 5'd2, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      drive(5'd1, 5'd0, 5'd2, 32'h0000_1234, 32'd5, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      chk("r0_nofwd_a", alu_a, 32'h0000_1234);

      // EX beats MEM, then MEM alone
      drive(5'd0, 5'd1, 5'd2, 32'd1, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(5'd0, 5'd5, 5'd5, 32'd99, 32'd99, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      alu_out = 32'd1;
      mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd5; mem_data = 32'd2;
      tick();
      chk("prio_ex_a", alu_a, 32'd1);
      chk("prio_ex_rtval", ex_rt_val, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("bubble_valid", 32'(ex_valid), 32'd0);
      drive(5'd0, 5'd5, 5'd6, 32'd99, 32'd7, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("prio_mem_a", alu_a, 32'd2);
      chk("prio_mem_b", alu_b, 32'd7);
      mem_valid = 1'b0;

      // Load-use
      drive(5'd0, 5'd1, 5'd2, 32'h100, 32'd0, 32'd8, 1'b1, 5'd4, 1'b1, 1'b1);
      tick();
      chk("ld_ex_load", 32'(ex_load), 32'd1);
      drive(5'd0, 5'd4, 5'd2, 32'd0, 32'd3, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      #1 chk("lu_ready0", 32'(in_ready), 32'd0);
      tick();
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd4; mem_data = 32'hF000_1231;
      #1 chk("lu_ready1", 32'(in_ready), 32'd1);
      tick();
      chk("lu_valid", 32'(ex_valid), 32'd1);
      chk("lu_a", alu_a, 32'hF000_1231);
`ifdef ALU_ISSUE_PERF_EN
      chk("lu_perf_hz", perf_hz_stalls, 32'd1);
      chk("lu_perf_issued", perf_issued, 32'd11);
`endif
      mem_valid = 1'b0;

      // Back-pressure
      ex_ready = 1'b0;
      drive(5'd2, 5'd10, 5'd11, 32'h11, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(ex_valid), 32'd1);
         chk("bp_a", alu_a, 32'hF000_1231);
         chk("bp_b", alu_b, 32'd3);
         tick();
      end
      ex_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp_next_a", alu_a, 32'h11);
      chk("bp_next_op", 32'(alu_op), 32'd2);

      // Flush with pending input, then flush during a stall
      drive(5'd3, 5'd12, 5'd11, 32'h22, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      flush = 1'b1;
      #1 chk("fl_ready", 32'(in_ready), 32'd0);
      tick();
      chk("fl_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      #1 chk("fl_pending_ready", 32'(in_ready), 32'd1);
      tick();
      chk("fl_after_valid", 32'(ex_valid), 32'd1);
      chk("fl_after_a", alu_a, 32'h22);
      in_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1;
      tick();
      chk("fl_stall_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0; ex_ready = 1'b1;

      // Reset asserted mid-stall
      drive(5'd3, 5'd13, 5'd14, 32'h33, 32'h44, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
      chk("rs_loaded_a", alu_a, 32'h33);
      in_valid = 1'b0; ex_ready = 1'b0;
      tick();
      chk("rs_stall_valid", 32'(ex_valid), 32'd1);
      in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rs_valid", 32'(ex_valid), 32'd0);
      chk("rs_a", alu_a, 32'd0);
      chk("rs_b", alu_b, 32'd0);
      chk("rs_rtval", ex_rt_val, 32'd0);
      chk("rs_op", 32'(alu_op), 32'd0);
      chk("rs_rd_wen", {26'd0, ex_rd, ex_wen}, 32'd0);
      chk("rs_ready", 32'(in_ready), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
      chk("rs_perf_issued", perf_issued, 32'd0);
`endif
      in_valid = 1'b0; ex_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized program against in-order semantics
      rf[0] = 32'd0; golden[0] = 32'd0;
      for (int i = 1; i < 32; i++) begin
         rf[i] = $urandom;
         golden[i] = rf[i];
      end
      s_v = 1'b0; m_v = 1'b0; p_v = 1'b0;
      s_op = 5'd0; s_rd = 5'd0; s_a = 32'd0; s_b = 32'd0; s_rtv = 32'd0; s_res = 32'd0;
      s_wen = 1'b0; s_ld = 1'b0; s_rtu = 1'b0;
      m_wen = 1'b0; m_rd = 5'd0; m_data = 32'd0;
      p_op = 5'd0; p_rs = 5'd0; p_rt = 5'd0; p_rd = 5'd0; p_imm = 32'd0;
      p_ui = 1'b0; p_wen = 1'b0; p_ld = 1'b0;
      n_issue_m = 0; n_hz_m = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!p_v && $urandom_range(0, 3) != 0) begin
            kind  = int'($urandom_range(0, 2));
            p_op  = 5'($urandom_range(0, 14));
            p_rs  = 5'($urandom_range(0, 7));
            p_rt  = 5'($urandom_range(0, 7));
            p_rd  = 5'($urandom_range(0, 7));
            p_imm = $urandom;
            p_ui  = 1'($urandom_range(0, 1));
            p_wen = (kind != 2);
            p_ld  = (kind == 1);
            p_v   = 1'b1;
         end
         in_valid   = p_v;
         in_op      = p_op;
         in_rs      = p_rs;
         in_rt      = p_rt;
         in_rs_val  = rf[p_rs];
         in_rt_val  = rf[p_rt];
         in_imm     = p_imm;
         in_use_imm = p_ui;
         in_rd      = p_rd;
         in_wen     = p_wen;
         in_load    = p_ld;
         ex_ready   = ($urandom_range(0, 3) != 0);
         alu_out    = s_v ? alu_fn(s_op, s_a, s_b) : $urandom;
         mem_valid  = m_v;
         mem_wen    = m_v ? m_wen : 1'($urandom_range(0, 1));
         mem_rd     = m_v ? m_rd : 5'($urandom_range(0, 7));
         mem_data   = m_v ? m_data : $urandom;

         hz_m  = p_v && s_v && s_ld && (s_rd != 5'd0) &&
                 ((s_rd == p_rs) || ((s_rd == p_rt) && (!p_ui || !p_wen)));
         adv_m  = !s_v || ex_ready;
         rdy_m  = adv_m && !hz_m;
         acc_m  = p_v && rdy_m;
         fire_m = s_v && ex_ready;
         if (p_v && hz_m && adv_m) n_hz_m++;

         #1;
         chk("rnd_in_ready", 32'(in_ready), 32'(rdy_m));
         chk("rnd_ex_valid", 32'(ex_valid), 32'(s_v));
         if (s_v) begin
            chk("rnd_alu_op", 32'(alu_op), 32'(s_op));
            chk("rnd_alu_a", alu_a, s_a);
            chk("rnd_alu_b", alu_b, s_b);
            chk("rnd_ex_ctl", {25'd0, ex_rd, ex_wen, ex_load}, {25'd0, s_rd, s_wen, s_ld});
            if (s_rtu) chk("rnd_ex_rt_val", ex_rt_val, s_rtv);
         end

         @(posedge clk);
         if (m_v && m_wen && (m_rd != 5'd0)) rf[m_rd] = m_data;
         if (fire_m) begin
            m_v = 1'b1; m_rd = s_rd; m_wen = s_wen; m_data = s_res;
         end else begin
            m_v = 1'b0;
         end
         if (acc_m) begin
            ga   = golden[p_rs];
            grtv = golden[p_rt];
            gb   = p_ui ? p_imm : grtv;
            s_op = p_op; s_a = ga; s_b = gb; s_rtv = grtv;
            s_rd = p_rd; s_wen = p_wen; s_ld = p_ld;
            s_rtu = !p_ui || !p_wen;
            s_res = p_ld ? memval(ga + gb) : alu_fn(p_op, ga, gb);
            if (p_wen && (p_rd != 5'd0)) golden[p_rd] = s_res;
            s_v = 1'b1;
            p_v = 1'b0;
            n_issue_m++;
         end else if (fire_m) begin
            s_v = 1'b0;
         end
         @(negedge clk);
      end
`ifdef ALU_ISSUE_PERF_EN
      chk("rnd_perf_issued", perf_issued, 32'(n_issue_m));
      chk("rnd_perf_hz", perf_hz_stalls, 32'(n_hz_m));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
